// File: rtl/param_delay_line.sv
// param_delay_line: a DEPTH-stage registered delay line for a WIDTH-bit word.
// Each stage carries its own valid bit. The line supports a shift enable
// (stall), a synchronous flush of the valid bits, a combinational bypass of
// the outputs, and an occupancy count of the stages holding valid data.
module param_delay_line #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       bypass,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  // Number of set bits in the stage valid vector; never exceeds DEPTH.
  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s = s + CW'(v[i]);
    end
    return s;
  endfunction

  // Data stages shift on en. Flush does not touch them, because data in a
  // stage whose valid bit is clear is never interpreted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else if (en) begin
      data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
  end

  // Valid bits: flush clears every stage and drops the incoming valid.
  // Otherwise they shift in lockstep with the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Occupancy is a function of registers only. It therefore changes only at
  // clock edges or on reset.
  assign count = popcount(vld_q);

  // Bypass turns the block into a wire. The pipeline behind it keeps running.
  assign out_data  = bypass ? in_data  : data_q[DEPTH-1];
  assign out_valid = bypass ? in_valid : vld_q[DEPTH-1];

endmodule

// File: tb/tb_param_delay_line.sv
// Directed, table-driven bench for param_delay_line. It covers a DEPTH=4
// instance and a DEPTH=1 instance that share the same input stimulus.
module tb_param_delay_line;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic       bypass = 1'b0;

  logic [7:0] out_data4;
  logic       out_valid4;
  logic [2:0] count4;
  logic [7:0] out_data1;
  logic       out_valid1;
  logic [0:0] count1;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  param_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .en(en),
    .flush(flush), .bypass(bypass), .out_data(out_data4),
    .out_valid(out_valid4), .count(count4)
  );

  param_delay_line #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h3C)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .en(en),
    .flush(flush), .bypass(bypass), .out_data(out_data1),
    .out_valid(out_valid1), .count(count1)
  );

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       en;
    logic       fl;
    logic       byp;
    logic [7:0] exp_d;
    logic       exp_v;
    logic [2:0] exp_c;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic run_vec(input int i);
    string tag;
    in_data  = tbl[i].d;
    in_valid = tbl[i].v;
    en       = tbl[i].en;
    flush    = tbl[i].fl;
    bypass   = tbl[i].byp;
    @(posedge clk);
    #1;
    tag = $sformatf("vec%0d", i);
    chk({tag, " out_data"},  32'(out_data4),  32'(tbl[i].exp_d));
    chk({tag, " out_valid"}, 32'(out_valid4), 32'(tbl[i].exp_v));
    chk({tag, " count"},     32'(count4),     32'(tbl[i].exp_c));
  endtask

  initial begin
    int n_a;
    // Stream 0x01..0x08; the first word appears after the 4th edge.
    for (int k = 1; k <= 8; k++) begin
      tbl.push_back('{8'(k), 1'b1, 1'b1, 1'b0, 1'b0,
                      (k >= 4) ? 8'(k - 3) : 8'h00, (k >= 4), (k >= 4) ? 3'd4 : 3'(k)});
    end
    // Stall for 3 edges with changing inputs: the outputs stay frozen.
    tbl.push_back('{8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 1'b1, 3'd4});
    tbl.push_back('{8'hEF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 1'b1, 3'd4});
    tbl.push_back('{8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 1'b1, 3'd4});
    // Resume: the sequence continues without loss or duplication.
    tbl.push_back('{8'h09, 1'b1, 1'b1, 1'b0, 1'b0, 8'h06, 1'b1, 3'd4});
    tbl.push_back('{8'h0A, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 3'd4});
    tbl.push_back('{8'h0B, 1'b1, 1'b1, 1'b0, 1'b0, 8'h08, 1'b1, 3'd4});
    // Flush with en=1 and in_valid=1: valids clear while the data shifts.
    tbl.push_back('{8'h0C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h09, 1'b0, 3'd0});
    // Bubble pattern 1,0,1,1,0, then zeros.
    tbl.push_back('{8'h20, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0A, 1'b0, 3'd1});
    tbl.push_back('{8'h21, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0B, 1'b0, 3'd1});
    tbl.push_back('{8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0C, 1'b0, 3'd2});
    tbl.push_back('{8'h23, 1'b1, 1'b1, 1'b0, 1'b0, 8'h20, 1'b1, 3'd3});
    tbl.push_back('{8'h24, 1'b0, 1'b1, 1'b0, 1'b0, 8'h21, 1'b0, 3'd2});
    tbl.push_back('{8'h25, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 3'd2});
    tbl.push_back('{8'h26, 1'b0, 1'b1, 1'b0, 1'b0, 8'h23, 1'b1, 3'd1});
    tbl.push_back('{8'h27, 1'b0, 1'b1, 1'b0, 1'b0, 8'h24, 1'b0, 3'd0});
    n_a = tbl.size();
    // Bypass rows: the outputs follow the inputs while the pipeline fills.
    tbl.push_back('{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 3'd1});
    tbl.push_back('{8'hA6, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA6, 1'b1, 3'd2});
    tbl.push_back('{8'hA7, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA7, 1'b1, 3'd3});
    tbl.push_back('{8'hA8, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA8, 1'b0, 3'd3});

    // Asynchronous reset, asserted mid-cycle.
    #2 rst = 1'b1;
    #1;
    chk("rst out_data",   32'(out_data4),  32'h00);
    chk("rst out_valid",  32'(out_valid4), 32'h0);
    chk("rst count",      32'(count4),     32'h0);
    chk("rst1 out_data",  32'(out_data1),  32'h3C);
    chk("rst1 count",     32'(count1),     32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < n_a; i++) run_vec(i);

    // Bypass is combinational: check before any edge.
    in_data = 8'hA5; in_valid = 1'b1; en = 1'b1; flush = 1'b0; bypass = 1'b1;
    #1;
    chk("byp comb data",  32'(out_data4),  32'hA5);
    chk("byp comb valid", 32'(out_valid4), 32'h1);
    chk("byp comb data1", 32'(out_data1),  32'hA5);
    #1;

    for (int i = n_a; i < tbl.size(); i++) run_vec(i);

    // Clearing bypass exposes the last stage without an edge.
    // Stage valids are now 1,1,1,0 from stage 3 to stage 0.
    bypass = 1'b0;
    #1;
    chk("unbyp data",  32'(out_data4),  32'hA5);
    chk("unbyp valid", 32'(out_valid4), 32'h1);
    chk("unbyp count", 32'(count4),     32'd3);

    // Mid-operation reset while count=3.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst count",  32'(count4),     32'd0);
    chk("midrst data",   32'(out_data4),  32'h00);
    chk("midrst valid",  32'(out_valid4), 32'h0);
    chk("midrst data1",  32'(out_data1),  32'h3C);
    chk("midrst valid1", 32'(out_valid1), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // DEPTH=1: a word appears one edge after it enters.
    in_data = 8'h77; in_valid = 1'b1; en = 1'b1; flush = 1'b0; bypass = 1'b0;
    @(posedge clk);
    #1;
    chk("d1 data",   32'(out_data1),  32'h77);
    chk("d1 valid",  32'(out_valid1), 32'h1);
    chk("d1 count",  32'(count1),     32'h1);
    in_data = 8'h78; in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("d1 data2",  32'(out_data1),  32'h78);
    chk("d1 valid2", 32'(out_valid1), 32'h0);
    chk("d1 count2", 32'(count1),     32'h0);
    // DEPTH=1 stall and flush.
    in_data = 8'h79; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = 8'h7A; en = 1'b0;
    @(posedge clk);
    #1;
    chk("d1 stall data", 32'(out_data1),  32'h79);
    chk("d1 stall cnt",  32'(count1),     32'h1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("d1 flush valid", 32'(out_valid1), 32'h0);
    chk("d1 flush cnt",   32'(count1),     32'h0);
    chk("d1 flush hold",  32'(out_data1),  32'h79);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
